// File: rtl/pending_decoder.sv
// pending_decoder: turns the priority encoder's {index, valid} stream into
// sticky pending bits and serves them one at a time over a valid/ready grant
// handshake, highest index first.
//
// state | meaning
// IDLE  | no grant open; registered pending examined for the highest set bit
// GRANT | grant offered; outputs held until grant_valid & grant_ready

module pending_decoder #(
    parameter int IDX_W = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic [IDX_W-1:0]        in_idx,
    input  logic                    in_valid,
    output logic [(2**IDX_W)-1:0]   pending,
    output logic [(2**IDX_W)-1:0]   grant,
    output logic [IDX_W-1:0]        grant_idx,
    output logic                    grant_valid,
    input  logic                    grant_ready,
    output logic                    overflow
);

    localparam int N = 2**IDX_W;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             r_state;
    logic [N-1:0]       r_pending;
    logic [N-1:0]       r_grant;
    logic [IDX_W-1:0]   r_grant_idx;
    logic               r_grant_valid;
    logic               r_overflow;

    logic [IDX_W-1:0]   w_hi_idx;
    logic               w_hs;
    logic [N-1:0]       w_set;
    logic [N-1:0]       w_drop;
    logic               w_ovf;

    // Highest set pending bit, plus the per-edge set/drop masks and overflow detect
    always_comb begin
        w_hi_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (r_pending[i]) begin
                w_hi_idx = IDX_W'(i);
            end
        end
        w_hs   = r_grant_valid & grant_ready;
        w_set  = in_valid ? (N'(1) << in_idx) : '0;
        w_drop = w_hs ? (N'(1) << r_grant_idx) : '0;
        // A request on the line being handshaken this edge is a fresh request, not a loss
        w_ovf  = in_valid & r_pending[in_idx] & ~(w_hs & (r_grant_idx == in_idx));
    end

    // Pending capture, overflow pulse and grant FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_pending     <= '0;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_overflow    <= 1'b0;
        end else if (clear) begin
            r_state       <= IDLE;
            r_pending     <= '0;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            // set is applied after drop so a same-line request survives its handshake
            r_pending  <= (r_pending & ~w_drop) | w_set;
            r_overflow <= w_ovf;
            case (r_state)
                IDLE: begin
                    if (r_pending != '0) begin
                        r_grant       <= N'(1) << w_hi_idx;
                        r_grant_idx   <= w_hi_idx;
                        r_grant_valid <= 1'b1;
                        r_state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_hs) begin
                        r_grant       <= '0;
                        r_grant_idx   <= '0;
                        r_grant_valid <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign pending     = r_pending;
    assign grant       = r_grant;
    assign grant_idx   = r_grant_idx;
    assign grant_valid = r_grant_valid;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_pending_decoder.sv
// tb_pending_decoder: directed scenarios followed by random traffic, all
// outputs compared every cycle against a behavioural model of the decoder.

module tb_pending_decoder;

    localparam int IDX_W = 3;
    localparam int N     = 2**IDX_W;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic [IDX_W-1:0] in_idx;
    logic             in_valid;
    logic [N-1:0]     pending;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             grant_ready;
    logic             overflow;

    pending_decoder #(.IDX_W(IDX_W)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .in_idx      (in_idx),
        .in_valid    (in_valid),
        .pending     (pending),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;
    int n_ovf;
    int hs_q[$];

    // model: set of pending lines, the open grant (-1 = none), last overflow
    bit m_pend[N];
    int m_gidx;
    bit m_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_pend_vec();
        logic [31:0] v;
        v = 0;
        for (int i = 0; i < N; i++) if (m_pend[i]) v = v | (32'd1 << i);
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) m_pend[i] = 0;
        m_gidx = -1;
        m_ovf  = 0;
    endtask

    task automatic m_edge(input bit clr, input bit v, input int idx, input bit rdy);
        bit hs;
        int hi;
        bit old[N];
        if (clr) begin
            m_reset();
            return;
        end
        old = m_pend;
        hs  = (m_gidx >= 0) && rdy;
        m_ovf = v && old[idx] && !(hs && m_gidx == idx);
        if (hs) m_pend[m_gidx] = 0;
        if (v)  m_pend[idx] = 1;
        if (m_gidx >= 0) begin
            if (hs) m_gidx = -1;
        end else begin
            hi = -1;
            for (int i = N-1; i >= 0; i--) begin
                if (old[i]) begin
                    hi = i;
                    break;
                end
            end
            m_gidx = hi;
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pending"},     32'(pending),     m_pend_vec());
        chk({tag, ".grant"},       32'(grant),       (m_gidx >= 0) ? (32'd1 << m_gidx) : 32'd0);
        chk({tag, ".grant_idx"},   32'(grant_idx),   (m_gidx >= 0) ? 32'(m_gidx) : 32'd0);
        chk({tag, ".grant_valid"}, 32'(grant_valid), 32'(m_gidx >= 0));
        chk({tag, ".overflow"},    32'(overflow),    32'(m_ovf));
    endtask

    // called at a negedge: drive, clock, update model, check at next negedge
    task automatic step(input string tag, input bit clr, input bit v, input int idx, input bit rdy);
        clear       = clr;
        in_valid    = v;
        in_idx      = IDX_W'(idx);
        grant_ready = rdy;
        if (grant_valid && rdy && !clr) hs_q.push_back(int'(grant_idx));
        @(posedge clk);
        m_edge(clr, v, idx, rdy);
        @(negedge clk);
        chk_all(tag);
        if (overflow) n_ovf++;
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        chk_all(tag);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk_all({tag, "_rel"});
    endtask

    initial begin
        n_vec = 0; n_err = 0; n_ovf = 0;
        clear = 0; in_valid = 0; in_idx = 0; grant_ready = 0;
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        chk_all("reset");
        rst_n = 1'b1;

        // single request on 5, consumer always ready
        step("single", 0, 1, 5, 1);
        chk("single.pend20", 32'(pending), 32'h20);
        step("single", 0, 0, 0, 1);
        chk("single.grant20", 32'(grant), 32'h20);
        step("single", 0, 0, 0, 1);
        chk("single.done", 32'(pending), 32'h0);
        step("single", 0, 0, 0, 1);

        // priority: hold a grant on 0 while 1, 6, 3 arrive, then drain
        hs_q.delete();
        step("prio", 0, 1, 0, 0);
        step("prio", 0, 0, 0, 0);
        step("prio", 0, 1, 1, 0);
        step("prio", 0, 1, 6, 0);
        step("prio", 0, 1, 3, 0);
        repeat (10) step("prio", 0, 0, 0, 1);
        chk("prio.count", 32'(hs_q.size()), 32'd4);
        if (hs_q.size() == 4) begin
            chk("prio.order0", 32'(hs_q[0]), 32'd0);
            chk("prio.order1", 32'(hs_q[1]), 32'd6);
            chk("prio.order2", 32'(hs_q[2]), 32'd3);
            chk("prio.order3", 32'(hs_q[3]), 32'd1);
        end

        // backpressure + overflow on line 2
        n_ovf = 0;
        step("ovf", 0, 1, 2, 0);
        step("ovf", 0, 0, 0, 0);
        step("ovf", 0, 1, 2, 0);
        step("ovf", 0, 0, 0, 0);
        step("ovf", 0, 0, 0, 0);
        chk("ovf.held_idx", 32'(grant_idx), 32'd2);
        chk("ovf.pulses", 32'(n_ovf), 32'd1);
        step("ovf", 0, 0, 0, 1);
        step("ovf", 0, 0, 0, 1);

        // same-edge handshake and capture on line 4
        n_ovf = 0;
        hs_q.delete();
        step("same", 0, 1, 4, 0);
        step("same", 0, 0, 0, 0);
        step("same", 0, 1, 4, 1);
        chk("same.pend4", 32'(pending[4]), 32'd1);
        step("same", 0, 0, 0, 1);
        step("same", 0, 0, 0, 1);
        step("same", 0, 0, 0, 1);
        chk("same.twice", 32'(hs_q.size()), 32'd2);
        chk("same.no_ovf", 32'(n_ovf), 32'd0);

        // clear during grant drops the simultaneous request on 7
        step("clr", 0, 1, 5, 0);
        step("clr", 0, 0, 0, 0);
        step("clr", 1, 1, 7, 1);
        chk("clr.pend", 32'(pending), 32'd0);
        step("clr", 0, 0, 0, 0);
        step("clr", 0, 0, 0, 0);

        // async reset mid-grant
        step("rst", 0, 1, 3, 0);
        step("rst", 0, 1, 6, 0);
        step("rst", 0, 0, 0, 0);
        async_reset("rst_mid");

        // random traffic with occasional clear and async reset
        for (int i = 0; i < 3000; i++) begin
            step("rand",
                 ($urandom_range(0, 40) == 0),
                 ($urandom_range(0, 1) == 1),
                 int'($urandom_range(0, N-1)),
                 ($urandom_range(0, 9) < 6));
            if (i % 997 == 500) async_reset("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
